// File: rtl/eth_domain_seq.sv
// Isolation and reset sequencer for the Ethernet/iDMA domain.
//
// Before the domain reset is asserted, the sequencer isolates the domain's AXI port and waits
// for the isolate stage to confirm. The port is released only after the reset has been
// released and has settled, so no AXI traffic is outstanding while the domain is in reset.
//
// Optional feature: define ETH_SEQ_TIMEOUT_EN to bound the two isolate handshakes. A timeout
// sets the sticky err_o flag.
//
// Ports:
//   clk_i          domain clock
//   rst_ni         asynchronous active-low reset
//   reset_req_i    pulse: request one full domain reset sequence
//   isolate_req_i  level: keep the domain isolated (park)
//   err_clr_i      pulse: clear sticky err_o (timeout build only)
//   axi_isolate_o  1 = isolate the AXI port
//   axi_isolated_i isolate stage reports fully isolated
//   eth_rst_no     active-low domain reset
//   irq_gate_o     1 = mask the Ethernet interrupt (any state but RUN)
//   busy_o         1 in any state but RUN
//   done_o         one-cycle pulse on entry to RUN
//   err_o          sticky handshake timeout flag
//   state_o        current state (debug)
module eth_domain_seq #(
    parameter int unsigned RstCycles     = 16,
    parameter int unsigned SettleCycles  = 8,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       reset_req_i,
    input  logic       isolate_req_i,
    input  logic       err_clr_i,
    output logic       axi_isolate_o,
    input  logic       axi_isolated_i,
    output logic       eth_rst_no,
    output logic       irq_gate_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    localparam int unsigned MaxRs     = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int unsigned MaxCycles = (MaxRs > TimeoutCycles) ? MaxRs : TimeoutCycles;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [CntWidth-1:0] RstLast    = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] SettleLast = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] CntMax     = {CntWidth{1'b1}};

    typedef enum logic [2:0] {
        StRun        = 3'd0,
        StIsoWait    = 3'd1,
        StHold       = 3'd2,
        StRstAssert  = 3'd3,
        StRstRelease = 3'd4,
        StDeisoWait  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                entering;

    logic                axi_isolate_q, axi_isolate_d;
    logic                eth_rst_nq, eth_rst_nd;
    logic                irq_gate_q, irq_gate_d;
    logic                done_q, done_d;

`ifdef ETH_SEQ_TIMEOUT_EN
    localparam logic [CntWidth-1:0] ToLast = CntWidth'(TimeoutCycles - 1);
    logic timeout;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
`endif

    always_comb begin
        state_d = state_q;
`ifdef ETH_SEQ_TIMEOUT_EN
        timeout = 1'b0;
`endif
        case (state_q)
            StRun: begin
                if (pend_q || reset_req_i || isolate_req_i) state_d = StIsoWait;
            end
            StIsoWait: begin
                // A dropped isolate_req_i is only honoured once HOLD is reached.
                if (axi_isolated_i) begin
                    state_d = pend_q ? StRstAssert : StHold;
`ifdef ETH_SEQ_TIMEOUT_EN
                end else if (cnt_q == ToLast) begin
                    state_d = StRstAssert;
                    timeout = 1'b1;
`endif
                end
            end
            StHold: begin
                if (pend_q)              state_d = StRstAssert;
                else if (!isolate_req_i) state_d = StDeisoWait;
            end
            StRstAssert: begin
                if (cnt_q == RstLast) state_d = StRstRelease;
            end
            StRstRelease: begin
                if (cnt_q == SettleLast) begin
                    if (pend_q)             state_d = StRstAssert;
                    else if (isolate_req_i) state_d = StHold;
                    else                    state_d = StDeisoWait;
                end
            end
            StDeisoWait: begin
                if (!axi_isolated_i) begin
                    state_d = StRun;
`ifdef ETH_SEQ_TIMEOUT_EN
                end else if (cnt_q == ToLast) begin
                    state_d = StRun;
                    timeout = 1'b1;
`endif
                end
            end
            default: state_d = StRstAssert;
        endcase

        entering = (state_d != state_q);

        // Counter measures time in the current state; it holds at all-ones rather than wrap.
        if (entering)             cnt_d = '0;
        else if (cnt_q == CntMax) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + 1'b1;

        // A request arriving on the same cycle as RST_ASSERT entry survives for one more round.
        pend_d = reset_req_i | (pend_q & ~(entering & (state_d == StRstAssert)));

`ifdef ETH_SEQ_TIMEOUT_EN
        if (timeout)        err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
        else                err_d = err_q;
`else
        err_d = 1'b0;
`endif

        // Outputs are decoded from the next state so the registered copies track state_q.
        axi_isolate_d = !((state_d == StRun) || (state_d == StDeisoWait));
        eth_rst_nd    = (state_d != StRstAssert);
        irq_gate_d    = (state_d != StRun);
        done_d        = (state_d == StRun) && (state_q != StRun);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StRstAssert;
            cnt_q         <= '0;
            pend_q        <= 1'b0;
            err_q         <= 1'b0;
            axi_isolate_q <= 1'b1;
            eth_rst_nq    <= 1'b0;
            irq_gate_q    <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            err_q         <= err_d;
            axi_isolate_q <= axi_isolate_d;
            eth_rst_nq    <= eth_rst_nd;
            irq_gate_q    <= irq_gate_d;
            done_q        <= done_d;
        end
    end

    assign axi_isolate_o = axi_isolate_q;
    assign eth_rst_no    = eth_rst_nq;
    assign irq_gate_o    = irq_gate_q;
    assign busy_o        = irq_gate_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule
